// File: rtl/tc_adder_vector_checker.sv
// LFSR-driven stimulus/response checker for the 8-bit mirror adder: applies
// {A,B,Cin} vectors, waits a settle window, compares {Cout,S} to a 9-bit sum.
module tc_adder_vector_checker #(
  parameter int          NUM_VECTORS   = 20,
  parameter logic [16:0] SEED          = 17'h1ACE5,
  parameter int          SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Cout,
  input  logic [7:0] S,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic       Cin,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       match,
  output logic [7:0] err_count,
  output logic [7:0] vec_count
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [16:0] SEED_EFF    = (SEED == 17'd0) ? 17'd1 : SEED;
  localparam logic [16:0] SEED_NEXT   = {SEED_EFF[15:0], SEED_EFF[16] ^ SEED_EFF[13]};
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [7:0]  LAST_VEC    = 8'(NUM_VECTORS);

  state_t      state;
  logic [16:0] lfsr;
  logic [16:0] lfsrNext;
  logic [3:0]  settleCnt;
  logic [8:0]  expected;
  logic        isMatch;
  logic [7:0]  errNext;
  logic [7:0]  vecNext;

  always_comb begin
    lfsrNext = {lfsr[15:0], lfsr[16] ^ lfsr[13]};
    expected = {1'b0, A} + {1'b0, B} + {8'd0, Cin};
    isMatch  = ({Cout, S} == expected);
    errNext  = (!isMatch && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
    vecNext  = vec_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED_EFF;
      settleCnt <= 4'd0;
      A         <= 8'd0;
      B         <= 8'd0;
      Cin       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      match     <= 1'b0;
      err_count <= 8'd0;
      vec_count <= 8'd0;
    end else begin
      case (state)
        // A restart from DONE reloads the seed so every run is identical.
        IDLE, DONE: begin
          if (start) begin
            {A, B, Cin} <= SEED_EFF;
            lfsr        <= SEED_NEXT;
            match       <= 1'b0;
            err_count   <= 8'd0;
            vec_count   <= 8'd0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            state       <= APPLY;
          end
        end
        APPLY: begin
          settleCnt <= SETTLE_LOAD;
          state     <= (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
        end
        SETTLE: begin
          settleCnt <= settleCnt - 4'd1;
          if (settleCnt <= 4'd1) state <= CHECK;
        end
        // The next vector is loaded on the compare edge to keep the period tight.
        CHECK: begin
          match     <= isMatch;
          err_count <= errNext;
          vec_count <= vecNext;
          if (vecNext == LAST_VEC) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (errNext == 8'd0);
            state <= DONE;
          end else begin
            {A, B, Cin} <= lfsr;
            lfsr        <= lfsrNext;
            state       <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_adder_vector_checker.sv
// Scoreboard bench: three checker instances (default, zero seed, 255 vectors)
// driven by a shared adder model with selectable faults.
module tb_tc_adder_vector_checker;

  localparam int NINST = 3;
  localparam int PER   = 3;
  localparam int MAXLEN = 255 * PER;
  localparam int NVS[NINST] = '{20, 20, 255};
  localparam logic [16:0] SEEDS[NINST] = '{17'h1ACE5, 17'h00000, 17'h1ACE5};

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] aS[NINST];
  logic [7:0] bS[NINST];
  logic [7:0] sS[NINST];
  logic [7:0] errS[NINST];
  logic [7:0] vecS[NINST];
  logic       cinS[NINST];
  logic       coutS[NINST];
  logic       busyS[NINST];
  logic       doneS[NINST];
  logic       passS[NINST];
  logic       matchS[NINST];

  int         mode;
  logic [7:0] faultSel;
  int         faultPos;
  bit         finishReq;

  typedef struct {
    int          inst;
    logic [36:0] tup;
    logic [63:0] tag;
  } snap_t;

  snap_t       snapQ[$];
  logic [33:0] sb[NINST][$];
  logic [36:0] startTup[NINST];
  logic [36:0] preTup[NINST];
  logic [36:0] doneTup[NINST];

  int nVectors;
  int nMiscompares;

  // Adder seen by the checker: ideal, S[0] stuck low, Cout stuck low,
  // fully inverted, or a single bit flipped on a data-dependent subset.
  function automatic logic [8:0] adderResp(input logic [7:0] a, input logic [7:0] b,
                                           input logic c, input int m,
                                           input logic [7:0] sel, input int pos);
    logic [8:0] r;
    r = {1'b0, a} + {1'b0, b} + {8'd0, c};
    case (m)
      1: r[0] = 1'b0;
      2: r[8] = 1'b0;
      3: r = ~r;
      4: if (((a ^ b) & sel) == 8'd0) r[pos] = ~r[pos];
      default: ;
    endcase
    return r;
  endfunction

  for (genvar i = 0; i < NINST; i++) begin : g
    tc_adder_vector_checker #(
      .NUM_VECTORS  (NVS[i]),
      .SEED         (SEEDS[i]),
      .SETTLE_CYCLES(1)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .Cout     (coutS[i]),
      .S        (sS[i]),
      .A        (aS[i]),
      .B        (bS[i]),
      .Cin      (cinS[i]),
      .busy     (busyS[i]),
      .done     (doneS[i]),
      .pass     (passS[i]),
      .match    (matchS[i]),
      .err_count(errS[i]),
      .vec_count(vecS[i])
    );
    assign {coutS[i], sS[i]} = adderResp(aS[i], bS[i], cinS[i], mode, faultSel, faultPos);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-run reference: walk the LFSR sequence, grade each vector against
  // the faulted adder, and queue per-vector and end-of-run expectations.
  task automatic modelRun(input int k);
    logic [16:0] lfsr;
    logic [7:0]  a, b, err;
    logic        c, mt;
    logic [8:0]  sum;
    lfsr = (SEEDS[k] == 17'd0) ? 17'd1 : SEEDS[k];
    err  = 8'd0;
    mt   = 1'b0;
    a = 8'd0; b = 8'd0; c = 1'b0;
    for (int v = 1; v <= NVS[k]; v++) begin
      a = lfsr[16:9];
      b = lfsr[8:1];
      c = lfsr[0];
      if (v == 1) startTup[k] = {a, b, c, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
      if (v == NVS[k]) preTup[k] = {a, b, c, 1'b1, 1'b0, 1'b0, mt, err, 8'(v - 1)};
      sum = 9'(a) + 9'(b) + 9'(c);
      mt  = (adderResp(a, b, c, mode, faultSel, faultPos) == sum);
      if (!mt && err != 8'd255) err = err + 8'd1;
      sb[k].push_back({a, b, c, mt, err, 8'(v)});
      lfsr = {lfsr[15:0], lfsr[16] ^ lfsr[13]};
    end
    doneTup[k] = {a, b, c, 1'b0, 1'b1, (err == 8'd0), mt, err, 8'(NVS[k])};
  endtask

  task automatic pushSnap(input int k, input logic [36:0] t, input logic [63:0] tag);
    snap_t s;
    s.inst = k;
    s.tup  = t;
    s.tag  = tag;
    snapQ.push_back(s);
  endtask

  task automatic applyStimulus(input int m, input bit doReset);
    int pulseAt;
    mode = m;
    if (m == 4) begin
      faultSel = 8'((1 << $urandom_range(0, 7)) | (1 << $urandom_range(0, 7)));
      faultPos = $urandom_range(0, 8);
    end
    for (int k = 0; k < NINST; k++) modelRun(k);
    pulseAt = $urandom_range(1, 50);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < NINST; k++) pushSnap(k, startTup[k], "start");
    for (int c = 1; c <= MAXLEN; c++) begin
      start = (c == pulseAt) && !doReset;
      if (doReset && c == 15) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (doReset && c == 15) begin
        for (int k = 0; k < NINST; k++) begin
          pushSnap(k, 37'd0, "midrst");
          sb[k].delete();
        end
        rst = 1'b0;
        break;
      end
      for (int k = 0; k < NINST; k++) begin
        if (c == NVS[k] * PER - 1) pushSnap(k, preTup[k], "predone");
        if (c == NVS[k] * PER)     pushSnap(k, doneTup[k], "done");
      end
    end
    repeat ($urandom_range(0, 4)) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input logic [63:0] tag, input int k,
                             input logic [36:0] act, input logic [36:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %0s inst%0d: got %h, expected %h", tag, k, act, exp);
    end
  endtask

  // Monitor: grades each compare when vec_count advances, drains snapshot
  // requests, and prints the summary once stimulus is finished.
  initial begin
    logic [7:0] prevA[NINST];
    logic [7:0] prevB[NINST];
    logic       prevCin[NINST];
    logic [7:0] prevVec[NINST];
    logic [33:0] e;
    snap_t s;
    nVectors     = 0;
    nMiscompares = 0;
    for (int k = 0; k < NINST; k++) begin
      prevA[k] = 8'd0; prevB[k] = 8'd0; prevCin[k] = 1'b0; prevVec[k] = 8'd0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NINST; k++) begin
        if (vecS[k] !== prevVec[k] && vecS[k] != 8'd0) begin
          if (sb[k].size() == 0) begin
            checkOutput("unexpvec", k, {3'd0, prevA[k], prevB[k], prevCin[k], matchS[k], errS[k], vecS[k]}, 37'h1FFFFFFFFF);
          end else begin
            e = sb[k].pop_front();
            checkOutput("vector", k, {3'd0, prevA[k], prevB[k], prevCin[k], matchS[k], errS[k], vecS[k]}, {3'd0, e});
          end
        end
        prevVec[k] = vecS[k];
        prevA[k]   = aS[k];
        prevB[k]   = bS[k];
        prevCin[k] = cinS[k];
      end
      while (snapQ.size() > 0) begin
        s = snapQ.pop_front();
        checkOutput(s.tag, s.inst,
                    {aS[s.inst], bS[s.inst], cinS[s.inst], busyS[s.inst], doneS[s.inst],
                     passS[s.inst], matchS[s.inst], errS[s.inst], vecS[s.inst]}, s.tup);
      end
      if (finishReq) begin
        for (int k = 0; k < NINST; k++)
          checkOutput("leftover", k, 37'(sb[k].size()), 37'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 0;
    faultSel  = 8'd0;
    faultPos  = 0;
    finishReq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < NINST; k++) pushSnap(k, 37'd0, "reset");
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NINST; k++) pushSnap(k, 37'd0, "idle");

    $display("[TB] ideal adder, start from IDLE");
    applyStimulus(0, 1'b0);
    $display("[TB] ideal adder, restart from DONE");
    applyStimulus(0, 1'b0);
    $display("[TB] S[0] stuck low");
    applyStimulus(1, 1'b0);
    $display("[TB] Cout stuck low");
    applyStimulus(2, 1'b0);
    $display("[TB] inverted adder outputs");
    applyStimulus(3, 1'b0);
    $display("[TB] data-dependent bit flip");
    applyStimulus(4, 1'b0);
    $display("[TB] reset during CHECK of vector 5");
    applyStimulus(0, 1'b1);
    $display("[TB] replay after reset");
    applyStimulus(0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    finishReq = 1'b1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tc_adder_vector_checker.md
Name: tc_adder_vector_checker

Overview:
Self-checking stimulus/response stage that sits directly upstream of the 8-bit mirror adder. It drives the adder's A, B and Cin inputs from a 17-bit LFSR and holds each vector for a settle window. It then samples Cout/S[7:0], compares them against an internally computed 9-bit reference sum, and accumulates pass/fail status for the run. It replaces free-running testbench stimulus with a synthesizable, restartable checker.

Parameters:
NUM_VECTORS, 20, number of vectors per run; legal range 1..255.
SEED, 17'h1ACE5, LFSR load value; a value of 0 is replaced by 17'h00001.
SETTLE_CYCLES, 1, extra cycles operands are held before compare; legal range 0..15.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a run; honoured only in IDLE or DONE
Cout  input  1  adder carry-out
S  input  8  adder sum bits S[7:0]
A  output  8  adder operand A (registered)
B  output  8  adder operand B (registered)
Cin  output  1  adder carry-in (registered)
busy  output  1  high in APPLY, SETTLE and CHECK
done  output  1  high in DONE
pass  output  1  valid while done; 1 iff err_count==0
match  output  1  result of the most recent compare
err_count  output  8  mismatches this run; saturates at 255
vec_count  output  8  vectors compared this run

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; A=B=0, Cin=0, match=0, err_count=0, vec_count=0, busy=0, done=0, pass=0; LFSR=SEED (or 1 if SEED==0). rst has priority over all other inputs, in every state.
- LFSR: 17-bit Fibonacci. next = {lfsr[15:0], lfsr[16]^lfsr[13]}. The vector mapping is {A,B,Cin} = lfsr, i.e. A=lfsr[16:9], B=lfsr[8:1], Cin=lfsr[0].
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE: outputs hold their reset values.
  - start=1 → load LFSR-derived operands into A/B/Cin from the current LFSR value, advance the LFSR, clear the counters and match, and go to APPLY.
- APPLY: 1 cycle.
  - Load settle counter = SETTLE_CYCLES.
  - Go to SETTLE if SETTLE_CYCLES>0, else go to CHECK.
- SETTLE: decrement the counter each cycle; go to CHECK when it reaches 1.
  - Operands are stable for exactly 1+SETTLE_CYCLES cycles before CHECK.
- CHECK: 1 cycle.
  - expected = {1'b0,A} + {1'b0,B} + Cin, computed at 9 bits with no truncation.
  - match <= ({Cout,S} == expected).
  - On mismatch, err_count <= err_count+1 unless it is already 255.
  - vec_count <= vec_count+1.
  - If vec_count+1 == NUM_VECTORS → DONE. Otherwise → APPLY, loading the next LFSR vector into A/B/Cin on the same edge and advancing the LFSR.
- Per-vector period is SETTLE_CYCLES+2 cycles. A full run is NUM_VECTORS*(SETTLE_CYCLES+2) cycles from the start edge to the DONE entry edge.
- DONE: done=1, pass=(err_count==0).
  - A/B/Cin, match and the counters hold.
  - start=1 → restart exactly as from IDLE. The LFSR is reloaded from SEED, so runs are repeatable.
- start while busy is ignored.
- match holds its value between compares. It is never cleared by DONE, only by rst or a new start.

Test Plan:
- Ideal adder model on Cout/S, defaults, start pulse → first operands A=8'hD6, B=8'h72, Cin=1 (expected 9'h149). Then done after 60 cycles, vec_count=20, err_count=0, pass=1, match=1.
- S[0] stuck at 0 → first compare gives match=0 (0x149 is odd). At done, err_count equals the count of odd expected sums (cross-check with the LFSR model) and pass=0.
- SEED=0 → first vector A=8'h00, B=8'h00, Cin=1, expected 9'h001. With Cout forced to 0, every vector with expected≥256 is flagged, and the count matches the reference model.
- rst asserted during CHECK of vector 5 → next cycle A=B=0, Cin=0, match=0, err_count=0, vec_count=0, busy=0. A following start replays vector 1 as D6/72/1.
- start pulsed while busy → no effect on vec_count/LFSR sequence. start in DONE → immediate restart with identical vector sequence and done deasserted.
- NUM_VECTORS=255 with the DUT inverted on all outputs → err_count saturates at 255 and does not wrap; pass=0.
